// File: rtl/hack_rom_loader.sv
// hack_rom_loader: boot loader and run controller for the Hack CPU.
// Holds the CPU in reset, streams a length-prefixed program from a byte
// receiver into instruction ROM, then releases the CPU; can re-enter load.
//
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   rx_data, rx_valid  : received byte and its one-cycle strobe
//   load_req           : pulse, re-enter load mode from RUN
//   go_run             : pulse, run the existing ROM from HDR_HI
//   rom_write          : one-cycle ROM write enable
//   rom_address        : ROM write address
//   rom_data           : ROM write data
//   cpu_reset, loading : high in every state except RUN
//   timeout_err        : sticky, transfer aborted by inter-byte timeout
//   overflow           : sticky, header word count exceeded ROM size

module hack_rom_loader #(
    parameter int WORD_WIDTH        = 16,
    parameter int ROM_ADDRESS_WIDTH = 15,
    parameter int TIMEOUT_CYCLES    = 1000000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    input  logic                         load_req,
    input  logic                         go_run,
    output logic                         rom_write,
    output logic [ROM_ADDRESS_WIDTH-1:0] rom_address,
    output logic [WORD_WIDTH-1:0]        rom_data,
    output logic                         cpu_reset,
    output logic                         loading,
    output logic                         timeout_err,
    output logic                         overflow
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    // One bit wider than the word count so 2^16 words is representable.
    localparam logic [16:0] ROM_WORDS = 17'd1 << ROM_ADDRESS_WIDTH;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA_HI,
        DATA_LO,
        RELEASE,
        RUN
    } state_t;

    state_t                       state_q, state_d;
    logic [15:0]                  count_q, count_d;
    logic [15:0]                  index_q, index_d;
    logic [7:0]                   hi_q, hi_d;
    logic [IDLE_W-1:0]            idle_q, idle_d;
    logic                         wr_q, wr_d;
    logic [ROM_ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_WIDTH-1:0]        data_q, data_d;
    logic                         cpu_reset_q, cpu_reset_d;
    logic                         timeout_q, timeout_d;
    logic                         overflow_q, overflow_d;

    logic [15:0] n_words;
    logic [15:0] index_inc;
    logic        idle_active;

    // Full count as it would be once the low header byte is taken.
    assign n_words     = {count_q[15:8], rx_data};
    assign index_inc   = index_q + 16'd1;
    assign idle_active = (state_q == HDR_LO) ||
                         (state_q == DATA_HI) ||
                         (state_q == DATA_LO);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        index_d    = index_q;
        hi_d       = hi_q;
        wr_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        timeout_d  = timeout_q;
        overflow_d = overflow_q;

        unique case (state_q)
            HDR_HI: begin
                if (rx_valid) begin
                    count_d    = {rx_data, 8'h00};
                    timeout_d  = 1'b0;
                    overflow_d = 1'b0;
                    state_d    = HDR_LO;
                end else if (go_run) begin
                    state_d = RELEASE;
                end
            end
            HDR_LO: begin
                if (rx_valid) begin
                    count_d = n_words;
                    index_d = 16'd0;
                    state_d = (n_words == 16'd0) ? RELEASE : DATA_HI;
                    if ({1'b0, n_words} > ROM_WORDS)
                        overflow_d = 1'b1;
                end
            end
            DATA_HI: begin
                if (rx_valid) begin
                    hi_d    = rx_data;
                    state_d = DATA_LO;
                end
            end
            DATA_LO: begin
                if (rx_valid) begin
                    // Words past the end of ROM are drained, not written.
                    if ({1'b0, index_q} < ROM_WORDS) begin
                        wr_d   = 1'b1;
                        addr_d = index_q[ROM_ADDRESS_WIDTH-1:0];
                        data_d = WORD_WIDTH'({hi_q, rx_data});
                    end
                    index_d = index_inc;
                    state_d = (index_inc == count_q) ? RELEASE : DATA_HI;
                end
            end
            RELEASE: begin
                state_d = RUN;
            end
            RUN: begin
                if (load_req)
                    state_d = HDR_HI;
            end
            default: begin
                state_d = HDR_HI;
            end
        endcase

        // A byte in the expiry cycle is taken, so rx_valid blocks abort.
        if (idle_active && !rx_valid && idle_q == IDLE_LAST) begin
            timeout_d = 1'b1;
            index_d   = 16'd0;
            state_d   = HDR_HI;
        end

        if (rx_valid || !idle_active || state_d != state_q)
            idle_d = '0;
        else
            idle_d = idle_q + IDLE_W'(1);

        cpu_reset_d = (state_d != RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HDR_HI;
            count_q     <= '0;
            index_q     <= '0;
            hi_q        <= '0;
            idle_q      <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            cpu_reset_q <= 1'b1;
            timeout_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            index_q     <= index_d;
            hi_q        <= hi_d;
            idle_q      <= idle_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cpu_reset_q <= cpu_reset_d;
            timeout_q   <= timeout_d;
            overflow_q  <= overflow_d;
        end
    end

    assign rom_write   = wr_q;
    assign rom_address = addr_q;
    assign rom_data    = data_q;
    assign cpu_reset   = cpu_reset_q;
    assign loading     = cpu_reset_q;
    assign timeout_err = timeout_q;
    assign overflow    = overflow_q;

endmodule
